// File: rtl/nf_rf_wb_ctrl_pkg.sv
// Shared types and helpers for the register-file write-back controller.
`include "nf_settings.svh"

package nf_rf_wb_ctrl_pkg;

  localparam int REG_NUM = `REG_NUMBER;
  localparam int AW      = 5;
  localparam int DW      = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rbuf_ent_t;

  // x0 is hard-wired, so it never reports busy regardless of the vector.
  function automatic logic reg_busy(input logic [REG_NUM-1:0] busy,
                                    input logic [AW-1:0]      ra);
    return (ra != '0) && busy[ra];
  endfunction

endpackage

// File: rtl/nf_settings.svh
// Build-time defaults shared by the write-back controller and its users.
`ifndef NF_SETTINGS_SVH
`define NF_SETTINGS_SVH

`define REG_NUMBER 32
`define LDQ_DEPTH  4
`define RBUF_DEPTH 2

`endif

// File: rtl/nf_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read port.
module nf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the same cycle also pops.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nf_rf_wb_ctrl.sv
// Register-file write-port arbiter: pipeline write-back has priority, load
// returns are buffered and drained into free slots; a busy vector interlocks decode.
`include "nf_settings.svh"

module nf_rf_wb_ctrl
  import nf_rf_wb_ctrl_pkg::*;
#(
  parameter int LDQ_DEPTH  = `LDQ_DEPTH,
  parameter int RBUF_DEPTH = `RBUF_DEPTH
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_wa,
  input  logic [DW-1:0] alu_wd,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_wa,
  input  logic          lsu_vld,
  input  logic [DW-1:0] lsu_rd,
  output logic          lsu_rdy,
  input  logic [AW-1:0] id_ra1,
  input  logic [AW-1:0] id_ra2,
  input  logic [AW-1:0] id_wa,
  output logic          stall,
  output logic          ld_full,
  output logic          ld_err,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          we3
);

  logic [AW-1:0]      ldq_head;
  logic               ldq_full, ldq_empty, ldq_push, ldq_pop;
  rbuf_ent_t          rbuf_head, rbuf_wdata;
  logic               rbuf_full, rbuf_empty, rbuf_pop;
  logic               alu_grant;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               ld_err_q, ld_err_d;

  assign ldq_push   = ld_issue & ~ldq_full;
  assign lsu_rdy    = ~rbuf_full & ~ldq_empty;
  assign ldq_pop    = lsu_vld & lsu_rdy;
  assign rbuf_wdata = '{addr: ldq_head, data: lsu_rd};
  assign ld_full    = ldq_full;
  assign ld_err     = ld_err_q;

  nf_sync_fifo #(.WIDTH(AW), .DEPTH(LDQ_DEPTH)) u_ldq (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (ldq_push),
    .pop_i   (ldq_pop),
    .wdata_i (ld_wa),
    .rdata_o (ldq_head),
    .full_o  (ldq_full),
    .empty_o (ldq_empty)
  );

  nf_sync_fifo #(.WIDTH($bits(rbuf_ent_t)), .DEPTH(RBUF_DEPTH)) u_rbuf (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (ldq_pop),
    .pop_i   (rbuf_pop),
    .wdata_i (rbuf_wdata),
    .rdata_o (rbuf_head),
    .full_o  (rbuf_full),
    .empty_o (rbuf_empty)
  );

  // Gating with resetn keeps the write port quiet while reset is held.
  assign alu_grant = resetn & alu_we & (alu_wa != '0);

  always_comb begin
    we3      = 1'b0;
    wa3      = '0;
    wd3      = '0;
    rbuf_pop = 1'b0;
    if (alu_grant) begin
      we3 = 1'b1;
      wa3 = alu_wa;
      wd3 = alu_wd;
    end else if (resetn && !rbuf_empty) begin
      rbuf_pop = 1'b1;
      if (rbuf_head.addr != '0) begin
        we3 = 1'b1;
        wa3 = rbuf_head.addr;
        wd3 = rbuf_head.data;
      end
    end
  end

  // Clear is applied before set so a same-cycle re-issue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (rbuf_pop) busy_d[rbuf_head.addr] = 1'b0;
    if (ldq_push) busy_d[ld_wa] = 1'b1;
    busy_d[0] = 1'b0;
    ld_err_d  = ld_err_q | (lsu_vld & ldq_empty);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign stall = reg_busy(busy_q, id_ra1) | reg_busy(busy_q, id_ra2) |
                 reg_busy(busy_q, id_wa) | (ldq_full & ld_issue);

endmodule

// File: tb/tb_nf_rf_wb_ctrl.sv
// Directed bench for nf_rf_wb_ctrl with a queue-based reference model.
module tb_nf_rf_wb_ctrl;

  localparam int LDQ = 4;
  localparam int RB  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        alu_we, ld_issue, lsu_vld;
  logic [4:0]  alu_wa, ld_wa, id_ra1, id_ra2, id_wa;
  logic [31:0] alu_wd, lsu_rd;
  logic        lsu_rdy, stall, ld_full, ld_err, we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  always #5 clk = ~clk;

  nf_rf_wb_ctrl #(.LDQ_DEPTH(LDQ), .RBUF_DEPTH(RB)) dut (
    .clk(clk), .resetn(resetn),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_issue(ld_issue), .ld_wa(ld_wa),
    .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_rdy(lsu_rdy),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_wa(id_wa),
    .stall(stall), .ld_full(ld_full), .ld_err(ld_err),
    .wa3(wa3), .wd3(wd3), .we3(we3)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: queues of pending destinations and buffered returns.
  typedef struct { bit [4:0] a; bit [31:0] d; } ent_t;
  ent_t      rb_m[$];
  bit [4:0]  pend_m[$];
  bit [31:0] busy_m;
  bit        err_m;

  initial begin
    int   np, nr;
    bit   rdy;
    ent_t e;
    busy_m = '0;
    err_m  = 1'b0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        rb_m.delete();
        pend_m.delete();
        busy_m = '0;
        err_m  = 1'b0;
      end else begin
        np  = pend_m.size();
        nr  = rb_m.size();
        rdy = (nr < RB) && (np > 0);
        if (!(alu_we && alu_wa != 0) && nr > 0) begin
          e = rb_m.pop_front();
          if (e.a != 0) busy_m[e.a] = 1'b0;
        end
        if (lsu_vld && rdy) begin
          e.a = pend_m.pop_front();
          e.d = lsu_rd;
          rb_m.push_back(e);
        end
        if (lsu_vld && np == 0) err_m = 1'b1;
        if (ld_issue && np < LDQ) begin
          pend_m.push_back(ld_wa);
          if (ld_wa != 0) busy_m[ld_wa] = 1'b1;
        end
      end
    end
  end

  initial begin
    bit        x_rdy, x_full, x_stall, x_we;
    bit [4:0]  x_wa;
    bit [31:0] x_wd;
    forever begin
      @(negedge clk);
      x_rdy   = resetn && (rb_m.size() < RB) && (pend_m.size() > 0);
      x_full  = resetn && (pend_m.size() == LDQ);
      x_stall = busy_m[id_ra1] | busy_m[id_ra2] | busy_m[id_wa] | (x_full & ld_issue);
      x_we = 1'b0; x_wa = '0; x_wd = '0;
      if (resetn) begin
        if (alu_we && alu_wa != 0) begin
          x_we = 1'b1; x_wa = alu_wa; x_wd = alu_wd;
        end else if (rb_m.size() > 0 && rb_m[0].a != 0) begin
          x_we = 1'b1; x_wa = rb_m[0].a; x_wd = rb_m[0].d;
        end
      end
      chk("m_lsu_rdy", lsu_rdy, x_rdy);
      chk("m_ld_full", ld_full, x_full);
      chk("m_stall",   stall,   x_stall);
      chk("m_ld_err",  ld_err,  err_m);
      chk("m_we3",     we3,     x_we);
      chk("m_wa3",     wa3,     x_wa);
      chk("m_wd3",     wd3,     x_wd);
    end
  end

  task automatic idle();
    alu_we = 0; alu_wa = 0; alu_wd = 0;
    ld_issue = 0; ld_wa = 0; lsu_vld = 0; lsu_rd = 0;
    id_ra1 = 0; id_ra2 = 0; id_wa = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    alu_we = 1; alu_wa = 3; alu_wd = 32'h55;
    @(negedge clk);
    chk("rst_we3", we3, 0); chk("rst_wa3", wa3, 0); chk("rst_wd3", wd3, 0);
    chk("rst_rdy", lsu_rdy, 0); chk("rst_stall", stall, 0);
    chk("rst_full", ld_full, 0); chk("rst_err", ld_err, 0);
    tick();
    idle();
    resetn = 1'b1;
    tick();

    // Basic load: issue, return, write-back one cycle later
    ld_issue = 1; ld_wa = 5;
    @(negedge clk); chk("a_stall0", stall, 0);
    tick(); idle();
    lsu_vld = 1; lsu_rd = 32'hDEADBEEF;
    @(negedge clk); chk("a_rdy", lsu_rdy, 1); chk("a_we_early", we3, 0);
    tick(); idle();
    id_ra1 = 5;
    @(negedge clk);
    chk("a_we3", we3, 1); chk("a_wa3", wa3, 5); chk("a_wd3", wd3, 32'hDEADBEEF);
    chk("a_stall1", stall, 1);
    tick();
    @(negedge clk); chk("a_busy_clr", stall, 0); chk("a_we_after", we3, 0);
    tick(); idle();

    // Decode interlock on a pending load destination
    ld_issue = 1; ld_wa = 7;
    tick(); idle();
    id_ra2 = 7;
    repeat (3) begin
      @(negedge clk); chk("b_stall_hold", stall, 1);
      tick();
    end
    lsu_vld = 1; lsu_rd = 32'h7777;
    @(negedge clk); chk("b_stall_ret", stall, 1);
    tick();
    lsu_vld = 0;
    @(negedge clk); chk("b_wa3", wa3, 7); chk("b_stall_wb", stall, 1);
    tick();
    @(negedge clk); chk("b_stall_rel", stall, 0);
    tick(); idle();

    // Pipeline write-back starves load returns; buffer fills and back-pressures
    for (int i = 0; i < 3; i++) begin
      ld_issue = 1; ld_wa = 5'(3 + i);
      tick();
    end
    idle();
    alu_we = 1; alu_wa = 9; alu_wd = 32'h99; lsu_vld = 1; lsu_rd = 32'h333;
    @(negedge clk); chk("c1_rdy", lsu_rdy, 1); chk("c1_wa3", wa3, 9); chk("c1_wd3", wd3, 32'h99);
    tick();
    alu_wd = 32'h9A; lsu_rd = 32'h444;
    @(negedge clk); chk("c2_rdy", lsu_rdy, 1); chk("c2_wa3", wa3, 9);
    tick();
    alu_wd = 32'h9B; lsu_rd = 32'h555;
    @(negedge clk); chk("c3_rdy", lsu_rdy, 0); chk("c3_wa3", wa3, 9); chk("c3_wd3", wd3, 32'h9B);
    tick();
    alu_we = 0;
    @(negedge clk); chk("c4_rdy", lsu_rdy, 0); chk("c4_we3", we3, 1);
    chk("c4_wa3", wa3, 3); chk("c4_wd3", wd3, 32'h333);
    tick();
    @(negedge clk); chk("c5_rdy", lsu_rdy, 1); chk("c5_wa3", wa3, 4); chk("c5_wd3", wd3, 32'h444);
    tick();
    lsu_vld = 0;
    @(negedge clk); chk("c6_wa3", wa3, 5); chk("c6_wd3", wd3, 32'h555);
    tick();
    @(negedge clk); chk("c7_we3", we3, 0);
    tick(); idle();

    // Pending queue fills; fifth issue dropped; returns retire in order
    for (int i = 0; i < 5; i++) begin
      ld_issue = 1; ld_wa = 5'(10 + i);
      @(negedge clk);
      if (i == 3) chk("d_full_pre", ld_full, 0);
      if (i == 4) begin chk("d_full", ld_full, 1); chk("d_stall_full", stall, 1); end
      tick();
    end
    idle();
    @(negedge clk); chk("d_full_hold", ld_full, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      lsu_vld = 1; lsu_rd = 32'hA0 + 32'(i);
      @(negedge clk);
      if (i > 0) begin
        chk("d_wa3", wa3, 32'(10 + i - 1)); chk("d_wd3", wd3, 32'hA0 + 32'(i - 1));
      end
      tick();
    end
    idle();
    id_wa = 14;
    @(negedge clk); chk("d_wa3_last", wa3, 13); chk("d_wd3_last", wd3, 32'hA3);
    chk("d_x14_not_busy", stall, 0); chk("d_rdy_empty", lsu_rdy, 0);
    tick(); idle();

    // Spurious return and a load to x0
    lsu_vld = 1; lsu_rd = 32'h123;
    @(negedge clk); chk("e_rdy", lsu_rdy, 0); chk("e_err_pre", ld_err, 0);
    tick(); idle();
    repeat (3) begin
      @(negedge clk); chk("e_err_sticky", ld_err, 1);
      tick();
    end
    ld_issue = 1; ld_wa = 0;
    @(negedge clk); chk("e_x0_stall", stall, 0);
    tick(); idle();
    lsu_vld = 1; lsu_rd = 32'hFFFF;
    @(negedge clk); chk("e_x0_rdy", lsu_rdy, 1);
    tick(); idle();
    @(negedge clk); chk("e_x0_we3", we3, 0); chk("e_x0_wa3", wa3, 0);
    tick();
    @(negedge clk); chk("e_x0_we3b", we3, 0); chk("e_x0_drained", lsu_rdy, 0);
    tick(); idle();

    // Reset with two loads pending and one return buffered
    for (int i = 0; i < 3; i++) begin
      ld_issue = 1; ld_wa = 5'(20 + i);
      tick();
    end
    idle();
    alu_we = 1; alu_wa = 1; alu_wd = 32'h11; lsu_vld = 1; lsu_rd = 32'h2020;
    tick();
    lsu_vld = 0; id_ra1 = 21;
    @(negedge clk);
    chk("f_pre_we3", we3, 1); chk("f_pre_wa3", wa3, 1);
    chk("f_pre_rdy", lsu_rdy, 1); chk("f_pre_stall", stall, 1);
    #1 resetn = 1'b0;
    #1;
    chk("f_rst_we3", we3, 0); chk("f_rst_wa3", wa3, 0); chk("f_rst_wd3", wd3, 0);
    chk("f_rst_rdy", lsu_rdy, 0); chk("f_rst_stall", stall, 0);
    chk("f_rst_full", ld_full, 0); chk("f_rst_err", ld_err, 0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk); chk("f_no_wb", we3, 0); chk("f_no_rdy", lsu_rdy, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
